// File: rtl/udp_ip_pkg.sv
// Shared UDP/IPv4 framing definitions used by the rx_unpack and tx_pack datapaths.
// Header word indices count 16-bit big-endian words from the first byte of the Ethernet header.
package udp_ip_pkg;

  localparam logic [15:0] ETH_TYPE_IP   = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL    = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
  localparam int          HDR_WORDS     = 21;
  localparam int          UDP_HDR_BYTES = 8;

  localparam logic [15:0] MAC_BCAST_WORD = 16'hFFFF;
  localparam logic [15:0] UDP_LEN_MIN    = 16'd9;

  localparam logic [4:0] W_MAC_LAST = 5'd2;
  localparam logic [4:0] W_ETYPE    = 5'd6;
  localparam logic [4:0] W_VER_IHL  = 5'd7;
  localparam logic [4:0] W_PROTO    = 5'd11;
  localparam logic [4:0] W_DIP_HI   = 5'd15;
  localparam logic [4:0] W_DIP_LO   = 5'd16;
  localparam logic [4:0] W_DPORT    = 5'd18;
  localparam logic [4:0] W_UDP_LEN  = 5'd19;
  localparam logic [4:0] W_HDR_LAST = 5'(HDR_WORDS - 1);

  localparam int          FIFO_DEPTH   = 8;
  localparam int          FIFO_AW      = 3;
  localparam logic [FIFO_AW:0] RDY_USED_MAX = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DISCARD = 2'd3
  } rx_state_e;

  typedef struct packed {
    logic [15:0] data;
    logic        sop;
    logic        eop;
    logic        mty;
  } stream_word_t;

  function automatic logic [15:0] mac_word(input logic [47:0] mac, input logic [4:0] idx);
    case (idx)
      5'd0:    return mac[47:32];
      5'd1:    return mac[31:16];
      default: return mac[15:0];
    endcase
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Synchronous FIFO holding unpacked payload words {data,sop,eop,mty} with an occupancy count.
// Read data is presented combinationally from the head entry; the consumer registers it.
module rx_fifo
  import udp_ip_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int W     = $bits(stream_word_t)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   used,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_wr;
  logic          do_rd;

  assign full    = (used == CNT_FULL);
  assign empty   = (used == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   used <= used + CNT_ONE;
        2'b01:   used <= used - CNT_ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rx_unpack.sv
// Receive-side UDP/IPv4 unpacker: validates the Ethernet/IP/UDP header against our own
// address and port, and forwards only the UDP payload, trimmed to the UDP length.
//
// state      | meaning
// -----------+----------------------------------------------------------------
// ST_IDLE    | waiting for din_sop; non-sop words are thrown away
// ST_HDR     | consuming header words 1..20, accumulating match flags
// ST_PAYLOAD | writing payload words to the FIFO until UDP length or eop
// ST_DISCARD | dropping words of a rejected frame (or trailing padding) until eop
module rx_unpack
  import udp_ip_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] cfg_mac_s,
  input  logic [31:0] cfg_sip,
  input  logic [15:0] cfg_sport,
  input  logic [15:0] din,
  input  logic        din_vld,
  input  logic        din_sop,
  input  logic        din_eop,
  input  logic        din_mty,
  output logic        din_rdy,
  output logic [15:0] dout,
  output logic        dout_vld,
  output logic        dout_sop,
  output logic        dout_eop,
  output logic        dout_mty,
  input  logic        dout_rdy,
  output logic        drop,
  output logic        err_trunc
);

  rx_state_e      state;
  logic [4:0]     hdr_cnt;
  logic [15:0]    udp_len;
  logic [15:0]    remaining;
  logic           mac_ok;
  logic           bcast_ok;
  logic           hdr_ok;
  logic           pay_first;
  logic           pad_strip;

  logic           mac_hit;
  logic           bc_hit;
  logic           word_ok;
  logic           last_pay;

  logic           fifo_wr;
  stream_word_t   fifo_wdata;
  logic           fifo_rd;
  stream_word_t   fifo_rdata;
  logic [FIFO_AW:0] fifo_used;
  logic           fifo_empty;

  assign mac_hit  = (din == mac_word(cfg_mac_s, hdr_cnt));
  assign bc_hit   = (din == MAC_BCAST_WORD);
  assign last_pay = (remaining <= 16'd2);

  always_comb begin
    word_ok = 1'b1;
    case (hdr_cnt)
      W_ETYPE:   word_ok = (din == ETH_TYPE_IP);
      W_VER_IHL: word_ok = (din[15:8] == IP_VER_IHL);
      W_PROTO:   word_ok = (din[7:0] == IP_PROTO_UDP);
      W_DIP_HI:  word_ok = (din == cfg_sip[31:16]);
      W_DIP_LO:  word_ok = (din == cfg_sip[15:0]);
      W_DPORT:   word_ok = (din == cfg_sport);
      W_UDP_LEN: word_ok = (din >= UDP_LEN_MIN);
      default:   word_ok = 1'b1;
    endcase
  end

  // Payload words go straight into the FIFO in their acceptance cycle to keep latency at 2.
  always_comb begin
    fifo_wr    = 1'b0;
    fifo_wdata = '0;
    if (din_vld && state == ST_PAYLOAD) begin
      fifo_wr         = 1'b1;
      fifo_wdata.data = din;
      fifo_wdata.sop  = pay_first;
      if (last_pay) begin
        fifo_wdata.eop = 1'b1;
        fifo_wdata.mty = (remaining == 16'd1);
      end else if (din_eop) begin
        fifo_wdata.eop = 1'b1;
        fifo_wdata.mty = din_mty;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hdr_cnt   <= '0;
      udp_len   <= '0;
      remaining <= '0;
      mac_ok    <= 1'b0;
      bcast_ok  <= 1'b0;
      hdr_ok    <= 1'b0;
      pay_first <= 1'b0;
      pad_strip <= 1'b0;
      din_rdy   <= 1'b0;
      drop      <= 1'b0;
      err_trunc <= 1'b0;
    end else begin
      drop      <= 1'b0;
      err_trunc <= 1'b0;
      // Three words can be in flight against a registered rdy, so stop at 5 used out of 8.
      din_rdy   <= (fifo_used <= RDY_USED_MAX);
      if (din_vld) begin
        case (state)
          ST_IDLE: begin
            if (din_sop) begin
              mac_ok   <= mac_hit;
              bcast_ok <= bc_hit;
              hdr_ok   <= 1'b1;
              if (din_eop) begin
                drop <= 1'b1;
              end else begin
                hdr_cnt <= 5'd1;
                state   <= ST_HDR;
              end
            end
          end
          ST_HDR: begin
            hdr_cnt <= hdr_cnt + 5'd1;
            hdr_ok  <= hdr_ok & word_ok;
            if (hdr_cnt <= W_MAC_LAST) begin
              mac_ok   <= mac_ok & mac_hit;
              bcast_ok <= bcast_ok & bc_hit;
            end
            if (hdr_cnt == W_UDP_LEN) udp_len <= din;
            if (din_eop) begin
              hdr_cnt <= '0;
              drop    <= 1'b1;
              state   <= ST_IDLE;
            end else if (hdr_cnt == W_HDR_LAST) begin
              hdr_cnt <= '0;
              if (hdr_ok && (mac_ok || bcast_ok)) begin
                remaining <= udp_len - 16'(UDP_HDR_BYTES);
                pay_first <= 1'b1;
                state     <= ST_PAYLOAD;
              end else begin
                pad_strip <= 1'b0;
                state     <= ST_DISCARD;
              end
            end
          end
          ST_PAYLOAD: begin
            pay_first <= 1'b0;
            if (last_pay) begin
              remaining <= '0;
              if (din_eop) begin
                state <= ST_IDLE;
              end else begin
                pad_strip <= 1'b1;
                state     <= ST_DISCARD;
              end
            end else if (din_eop) begin
              remaining <= '0;
              err_trunc <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              remaining <= remaining - 16'd2;
            end
          end
          ST_DISCARD: begin
            if (din_eop) begin
              drop      <= !pad_strip;
              pad_strip <= 1'b0;
              state     <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(stream_word_t))
  ) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wdata),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rdata),
    .used    (fifo_used),
    .empty   (fifo_empty)
  );

  assign fifo_rd = dout_rdy && !fifo_empty;

  // dout keeps its last value between reads; the qualifiers return to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout     <= '0;
      dout_vld <= 1'b0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
      dout_mty <= 1'b0;
    end else if (fifo_rd) begin
      dout     <= fifo_rdata.data;
      dout_vld <= 1'b1;
      dout_sop <= fifo_rdata.sop;
      dout_eop <= fifo_rdata.eop;
      dout_mty <= fifo_rdata.mty;
    end else begin
      dout_vld <= 1'b0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
      dout_mty <= 1'b0;
    end
  end

endmodule
